// File: rtl/usr_serial_ctrl.sv
// ---------------------------------------------------------------------------
// usr_serial_ctrl
//   Sequences an external 4-bit universal shift register through one serial
//   transfer. A request word is loaded in parallel and then shifted out one
//   bit per shift step. On each step the external sdi bit is shifted in, so
//   after four steps the register holds the received word, which is offered
//   on a valid/ready response port. An optional hold gap of BIT_GAP cycles
//   separates consecutive shift steps.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake; req_data, req_dir captured on accept
//   abort             returns any non-idle state to IDLE on the next edge
//   sdi, sdo          serial in from outside / serial bit leaving the register
//   sdo_valid         high on every shift cycle
//   usr_mode          00 hold, 01 right, 10 left, 11 load
//   usr_data_in       parallel load value (non-zero only in LOAD)
//   usr_serial_in     serial input to the register (sdi during SHIFT)
//   usr_data_out      register contents q
//   rsp_valid/ready   response handshake; rsp_data is the received word
//   busy              high in every state except IDLE
// ---------------------------------------------------------------------------
module usr_serial_ctrl #(
    parameter int unsigned BIT_GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_data,
    input  logic       req_dir,
    input  logic       abort,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_valid,
    output logic [1:0] usr_mode,
    output logic [3:0] usr_data_in,
    output logic       usr_serial_in,
    input  logic [3:0] usr_data_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // The gap counter is loaded with the index of the last gap cycle and
    // runs down to zero, so a gap lasts exactly BIT_GAP cycles.
    localparam logic [3:0] GAP_LAST = (BIT_GAP > 0) ? 4'(BIT_GAP - 1) : 4'd0;

    state_t     state_q;
    logic [3:0] data_q;
    logic       dir_q;
    logic [1:0] bit_cnt_q;
    logic [3:0] gap_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= 4'd0;
            dir_q     <= 1'b0;
            bit_cnt_q <= 2'd0;
            gap_cnt_q <= 4'd0;
        end else if (abort && (state_q != S_IDLE)) begin
            // abort wins over rsp_ready and over any state advancement
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        data_q  <= req_data;
                        dir_q   <= req_dir;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bit_cnt_q <= 2'd0;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
                        state_q <= S_DONE;
                    end else if (BIT_GAP > 0) begin
                        gap_cnt_q <= GAP_LAST;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= S_SHIFT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state; sdo and rsp_data follow
    // the register contents directly so they are valid in the same cycle.
    always_comb begin
        req_ready     = 1'b0;
        busy          = 1'b1;
        usr_mode      = MODE_HOLD;
        usr_data_in   = 4'd0;
        usr_serial_in = 1'b0;
        sdo           = 1'b0;
        sdo_valid     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = 4'd0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD: begin
                usr_mode    = MODE_LOAD;
                usr_data_in = data_q;
            end
            S_SHIFT: begin
                usr_mode      = dir_q ? MODE_LEFT : MODE_RIGHT;
                usr_serial_in = sdi;
                sdo           = dir_q ? usr_data_out[3] : usr_data_out[0];
                sdo_valid     = 1'b1;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = usr_data_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usr_serial_ctrl
//   Two controllers (BIT_GAP = 0 and BIT_GAP = 2) share one set of inputs,
//   each driving its own behavioural universal shift register. Expected
//   outputs are derived per cycle from the transfer timeline: accept at
//   cycle 0, load at 1, shifts every (G+1) cycles from 2, response from
//   6+3G until released, idle after abort/reset.
// ---------------------------------------------------------------------------
module tb_usr_serial_ctrl;

    localparam int R = 14;          // cycle offset at which rsp_ready is pulsed
    localparam int NOKILL = 1000;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_data;
    logic       req_dir;
    logic       abort;
    logic       sdi;
    logic       rsp_ready;

    logic       ready_w [2];
    logic       busy_w  [2];
    logic [1:0] mode_w  [2];
    logic [3:0] din_w   [2];
    logic       sin_w   [2];
    logic       sdo_w   [2];
    logic       sdov_w  [2];
    logic       rspv_w  [2];
    logic [3:0] rspd_w  [2];
    logic [3:0] q_w     [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic       sdi_hist [0:31];
    logic [3:0] sdo_seq0;
    logic [3:0] rsp_seen0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [3:0] q = 4'd0;

        usr_serial_ctrl #(.BIT_GAP(g * 2)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_ready    (ready_w[g]),
            .req_data     (req_data),
            .req_dir      (req_dir),
            .abort        (abort),
            .sdi          (sdi),
            .sdo          (sdo_w[g]),
            .sdo_valid    (sdov_w[g]),
            .usr_mode     (mode_w[g]),
            .usr_data_in  (din_w[g]),
            .usr_serial_in(sin_w[g]),
            .usr_data_out (q),
            .rsp_valid    (rspv_w[g]),
            .rsp_ready    (rsp_ready),
            .rsp_data     (rspd_w[g]),
            .busy         (busy_w[g])
        );

        // behavioural universal shift register
        always @(posedge clk) begin
            case (mode_w[g])
                2'b01:   q <= {sin_w[g], q[3:1]};
                2'b10:   q <= {q[2:0], sin_w[g]};
                2'b11:   q <= din_w[g];
                default: q <= q;
            endcase
        end
        assign q_w[g] = q;
    end

    task automatic chk(input string tag, input int k, input int c,
                       input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s u%0d cyc%0d observed=%0h expected=%0h", tag, k, c, obs, exp);
        end
    endtask

    // Expected outputs of both controllers at cycle offset c of a transfer.
    task automatic check_all(input int c, input int kill, input logic [3:0] d,
                             input logic dir, input logic force_idle);
        for (int k = 0; k < 2; k++) begin
            int         gap;
            int         p;
            int         bi;
            logic       idle, ld, sh, dn;
            logic [3:0] e_rsp;
            logic [1:0] e_mode;
            logic       e_sdo;
            gap  = k * 2;
            idle = force_idle || (c == 0) || (c > R) || (c > kill);
            ld   = !idle && (c == 1);
            dn   = !idle && (c >= 6 + 3 * gap);
            p    = c - 2;
            sh   = !idle && !ld && !dn && ((p % (gap + 1)) == 0);
            bi   = (p >= 0) ? p / (gap + 1) : 0;
            e_rsp = 4'd0;
            for (int i = 0; i < 4; i++) begin
                logic b;
                b = sdi_hist[2 + i * (gap + 1)];
                if (dir) e_rsp[3 - i] = b;
                else     e_rsp[i]     = b;
            end
            e_mode = ld ? 2'b11 : (sh ? (dir ? 2'b10 : 2'b01) : 2'b00);
            e_sdo  = sh ? (dir ? d[3 - bi] : d[bi]) : 1'b0;
            chk("req_ready", k, c, {3'b0, ready_w[k]}, {3'b0, idle});
            chk("busy",      k, c, {3'b0, busy_w[k]},  {3'b0, !idle});
            chk("usr_mode",  k, c, {2'b0, mode_w[k]},  {2'b0, e_mode});
            chk("usr_data_in", k, c, din_w[k], ld ? d : 4'd0);
            chk("usr_serial_in", k, c, {3'b0, sin_w[k]}, {3'b0, sh ? sdi : 1'b0});
            chk("sdo_valid", k, c, {3'b0, sdov_w[k]}, {3'b0, sh});
            chk("sdo",       k, c, {3'b0, sdo_w[k]},  {3'b0, e_sdo});
            chk("rsp_valid", k, c, {3'b0, rspv_w[k]}, {3'b0, dn});
            chk("rsp_data",  k, c, rspd_w[k], dn ? e_rsp : 4'd0);
            if (k == 0 && sh && !force_idle) sdo_seq0[bi] = sdo_w[0];
            if (k == 0 && dn && !force_idle) rsp_seen0 = rspd_w[0];
        end
    endtask

    // kind: 0 none, 1 abort at cycle kc, 2 reset pulse during cycle kc
    task automatic run(input logic [3:0] d, input logic dir, input logic [3:0] sdi_fix,
                       input logic use_fix, input int kc, input int kind);
        int kill;
        kill = (kind != 0 && kc >= 1) ? kc : NOKILL;
        sdo_seq0  = 4'd0;
        rsp_seen0 = 4'd0;
        for (int c = 0; c <= R + 2; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (c == 0) begin
                req_valid = 1'b1;
                req_data  = d;
                req_dir   = dir;
            end else begin
                // requests while busy must be ignored; none once idle again
                req_valid = (c <= R && c <= kill) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_data  = 4'($urandom_range(0, 15));
                req_dir   = 1'($urandom_range(0, 1));
            end
            sdi = (use_fix && c >= 2 && c <= 5) ? sdi_fix[c - 2] : 1'($urandom_range(0, 1));
            sdi_hist[c] = sdi;
            rsp_ready = (c == R) || (c < 6 && 1'($urandom_range(0, 1)));
            abort     = (kind == 1 && c == kc);
            @(negedge clk);
            check_all(c, kill, d, dir, 1'b0);
            if (kind == 2 && c == kc) begin
                rst = 1'b1;
                #1;
                check_all(c, kill, d, dir, 1'b1);
            end
        end
        req_valid = 1'b0;
        abort     = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_data = 4'd0;
        req_dir = 1'b0;
        abort = 1'b0;
        sdi = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) sdi_hist[i] = 1'b0;

        #3;
        check_all(0, NOKILL, 4'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // right shift, sdi 1,1,0,1
        run(4'b1010, 1'b0, 4'b1011, 1'b1, 0, 0);
        chk("ex1_sdo_seq", 0, 0, sdo_seq0, 4'b1010);
        chk("ex1_rsp", 0, 0, rsp_seen0, 4'b1011);

        // left shift, sdi 1,0,0,0
        run(4'b1010, 1'b1, 4'b0001, 1'b1, 0, 0);
        chk("ex2_sdo_seq", 0, 0, sdo_seq0, 4'b0101);
        chk("ex2_rsp", 0, 0, rsp_seen0, 4'b1000);

        // abort after the second shift, then a normal transfer
        run(4'b0110, 1'b0, 4'd0, 1'b0, 4, 1);
        run(4'b1001, 1'b1, 4'd0, 1'b0, 0, 0);

        // abort in IDLE together with a request: request still taken
        run(4'b0011, 1'b0, 4'd0, 1'b0, 0, 1);

        // abort in DONE, and abort together with rsp_ready
        run(4'b1100, 1'b1, 4'd0, 1'b0, 10, 1);
        run(4'b0101, 1'b0, 4'd0, 1'b0, R, 1);

        // abort in LOAD
        run(4'b1110, 1'b0, 4'd0, 1'b0, 1, 1);

        // reset during SHIFT, then a normal transfer
        run(4'b0111, 1'b1, 4'd0, 1'b0, 3, 2);
        run(4'b1011, 1'b0, 4'd0, 1'b0, 0, 0);

        // randomized transfers, some with an abort at a random point
        for (int t = 0; t < 8; t++) begin
            logic [3:0] d;
            logic       dir;
            int         kind;
            d    = 4'($urandom_range(0, 15));
            dir  = 1'($urandom_range(0, 1));
            kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run(d, dir, 4'd0, 1'b0, int'($urandom_range(1, R)), kind);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
